// File: rtl/dht22_sched_pkg.sv
// Shared types and helpers for the DHT22 poll scheduler.
package dht22_sched_pkg;

  localparam int unsigned MS_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    HOLDOFF,
    START,
    WAIT,
    CHECK,
    ABORT,
    RETRY
  } sched_state_e;

  // DHT22 checksum: byte-wise sum of humidity and temperature, modulo 256
  function automatic logic [7:0] dht_sum(input logic [15:0] hum, input logic [15:0] tmp);
    return hum[15:8] + hum[7:0] + tmp[15:8] + tmp[7:0];
  endfunction

endpackage

// File: rtl/dht22_poll_scheduler_ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle tick every CLK_PER_MS clocks.
module ms_tick_gen #(
  parameter int unsigned CLK_PER_MS = 100_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Down-counter reloads on terminal count and emits the tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= RELOAD;
      r_tick <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt  <= RELOAD;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt - 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/dht22_poll_scheduler.sv
// DHT22 poll scheduler: periodic / on-demand reads with minimum-interval
// holdoff, timeout abort, checksum check, retries and last-good data hold.
// Optional statistics counters: define DHT22_SCHED_STATS_EN.
//
// state   | meaning
// IDLE    | no transaction; waiting for trig or periodic request
// HOLDOFF | request accepted; waiting for minimum start spacing
// START   | dht_start pulse out
// WAIT    | waiting for dht_valid or timeout
// CHECK   | verifying captured checksum
// ABORT   | dht_abort / err_timeout pulse out
// RETRY   | decide between another attempt and giving up
module dht22_poll_scheduler
  import dht22_sched_pkg::*;
#(
  parameter int unsigned CLK_PER_MS      = 100_000,
  parameter int unsigned POLL_PERIOD_MS  = 5000,
  parameter int unsigned MIN_INTERVAL_MS = 2000,
  parameter int unsigned TIMEOUT_MS      = 20,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_trig,
  output logic        o_dht_start,
  output logic        o_dht_abort,
  input  logic        i_dht_valid,
  input  logic [15:0] i_dht_humidity,
  input  logic [15:0] i_dht_temperature,
  input  logic [7:0]  i_dht_checksum,
  output logic [15:0] o_humidity,
  output logic [15:0] o_temperature,
  output logic        o_data_ok,
  output logic        o_sample_valid,
  output logic        o_err_checksum,
  output logic        o_err_timeout,
  output logic        o_fail,
  output logic        o_busy,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_fail_cnt
);

  localparam int unsigned EFF_PERIOD_MS =
    (POLL_PERIOD_MS > MIN_INTERVAL_MS) ? POLL_PERIOD_MS : MIN_INTERVAL_MS;
  localparam logic [MS_W-1:0] PERIOD_LIM = 16'(EFF_PERIOD_MS);
  localparam logic [MS_W-1:0] IVAL_LIM   = 16'(MIN_INTERVAL_MS);
  localparam logic [MS_W-1:0] TO_LIM     = 16'(TIMEOUT_MS);
  localparam logic [7:0]      RETRY_LIM  = 8'(MAX_RETRY);

  logic            w_tick;
  sched_state_e    r_state;
  logic [MS_W-1:0] r_ival_ms, r_period_ms, r_to_ms;
  logic            r_trig_pend;
  logic [7:0]      r_retry;
  logic [15:0]     r_cap_hum, r_cap_tmp;
  logic [7:0]      r_cap_cks;
  logic [15:0]     r_humidity, r_temperature;
  logic            r_data_ok, r_sample_valid, r_err_checksum, r_err_timeout;
  logic            r_fail, r_dht_start, r_dht_abort;

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  // Millisecond timers: saturate at their limit, restart while a start is issued.
  // period_ms resets saturated so the first periodic poll is requested at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ival_ms   <= '0;
      r_period_ms <= PERIOD_LIM;
      r_to_ms     <= '0;
    end else if (r_state == START) begin
      r_ival_ms   <= '0;
      r_period_ms <= '0;
      r_to_ms     <= '0;
    end else if (w_tick) begin
      if (r_ival_ms < IVAL_LIM)     r_ival_ms   <= r_ival_ms + 16'd1;
      if (r_period_ms < PERIOD_LIM) r_period_ms <= r_period_ms + 16'd1;
      if (r_to_ms < TO_LIM)         r_to_ms     <= r_to_ms + 16'd1;
    end
  end

  // One-deep on-demand request; a trig coinciding with START is kept, not lost
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_trig_pend <= 1'b0;
    else if (i_trig)           r_trig_pend <= 1'b1;
    else if (r_state == START) r_trig_pend <= 1'b0;
  end

  // Transaction sequencer with registered pulse outputs and held sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_retry        <= '0;
      r_cap_hum      <= '0;
      r_cap_tmp      <= '0;
      r_cap_cks      <= '0;
      r_humidity     <= '0;
      r_temperature  <= '0;
      r_data_ok      <= 1'b0;
      r_sample_valid <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_fail         <= 1'b0;
      r_dht_start    <= 1'b0;
      r_dht_abort    <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_err_checksum <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_fail         <= 1'b0;
      r_dht_start    <= 1'b0;
      r_dht_abort    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_trig_pend || (i_enable && (r_period_ms >= PERIOD_LIM))) r_state <= HOLDOFF;
        end
        HOLDOFF: begin
          if (r_ival_ms >= IVAL_LIM) begin
            r_state     <= START;
            r_dht_start <= 1'b1;
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          if (i_dht_valid) begin
            r_cap_hum <= i_dht_humidity;
            r_cap_tmp <= i_dht_temperature;
            r_cap_cks <= i_dht_checksum;
            r_state   <= CHECK;
          end else if (r_to_ms >= TO_LIM) begin
            r_state       <= ABORT;
            r_dht_abort   <= 1'b1;
            r_err_timeout <= 1'b1;
          end
        end
        CHECK: begin
          if (dht_sum(r_cap_hum, r_cap_tmp) == r_cap_cks) begin
            r_humidity     <= r_cap_hum;
            r_temperature  <= r_cap_tmp;
            r_sample_valid <= 1'b1;
            r_data_ok      <= 1'b1;
            r_retry        <= '0;
            r_state        <= IDLE;
          end else begin
            r_err_checksum <= 1'b1;
            r_state        <= RETRY;
          end
        end
        ABORT: r_state <= RETRY;
        RETRY: begin
          if (r_retry < RETRY_LIM) begin
            r_retry <= r_retry + 8'd1;
            r_state <= HOLDOFF;
          end else begin
            r_fail  <= 1'b1;
            r_retry <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DHT22_SCHED_STATS_EN
  logic [15:0] r_good_cnt, r_fail_cnt;

  // Saturating event counters, advanced the cycle after each pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_good_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      if (r_sample_valid && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
      if (r_fail && (r_fail_cnt != 16'hFFFF))         r_fail_cnt <= r_fail_cnt + 16'd1;
    end
  end

  assign o_good_cnt = r_good_cnt;
  assign o_fail_cnt = r_fail_cnt;
`else
  assign o_good_cnt = '0;
  assign o_fail_cnt = '0;
`endif

  assign o_dht_start    = r_dht_start;
  assign o_dht_abort    = r_dht_abort;
  assign o_humidity     = r_humidity;
  assign o_temperature  = r_temperature;
  assign o_data_ok      = r_data_ok;
  assign o_sample_valid = r_sample_valid;
  assign o_err_checksum = r_err_checksum;
  assign o_err_timeout  = r_err_timeout;
  assign o_fail         = r_fail;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_dht22_poll_scheduler.sv
// Self-checking bench for dht22_poll_scheduler (reduced timing parameters).
// Honours DHT22_SCHED_STATS_EN when the design is built with it.
`timescale 1ns/1ps
module tb_dht22_poll_scheduler;

  localparam int CPM  = 10;
  localparam int POLL = 50;
  localparam int MINI = 20;
  localparam int TOUT = 5;
  localparam int MAXR = 2;

`ifdef DHT22_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, trig = 1'b0, dv = 1'b0;
  logic [15:0] dh = '0, dt = '0;
  logic [7:0]  dc = '0;
  logic        o_dht_start, o_dht_abort, o_data_ok, o_sample_valid;
  logic        o_err_checksum, o_err_timeout, o_fail, o_busy;
  logic [15:0] o_humidity, o_temperature, o_good_cnt, o_fail_cnt;

  dht22_poll_scheduler #(
    .CLK_PER_MS(CPM), .POLL_PERIOD_MS(POLL), .MIN_INTERVAL_MS(MINI),
    .TIMEOUT_MS(TOUT), .MAX_RETRY(MAXR)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_trig(trig),
    .o_dht_start(o_dht_start), .o_dht_abort(o_dht_abort),
    .i_dht_valid(dv), .i_dht_humidity(dh), .i_dht_temperature(dt), .i_dht_checksum(dc),
    .o_humidity(o_humidity), .o_temperature(o_temperature), .o_data_ok(o_data_ok),
    .o_sample_valid(o_sample_valid), .o_err_checksum(o_err_checksum),
    .o_err_timeout(o_err_timeout), .o_fail(o_fail), .o_busy(o_busy),
    .o_good_cnt(o_good_cnt), .o_fail_cnt(o_fail_cnt)
  );

  always #5 clk = ~clk;

  // Edges since reset release; outputs observed on the falling edge carry this index
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask

  // Reference model: scheduled outcomes keyed by observation cycle
  logic [15:0] exp_h[int], exp_t[int];
  bit          exp_ec[int], exp_fail[int];
  logic [15:0] m_hum, m_tmp;
  logic        m_ok;
  int          m_good, m_fail;
  bit          sv_prev, fail_prev, e_sv, e_ec, e_fl;
  bit          start_ok = 1'b0, abort_ok = 1'b0;
  int          phase = 1;

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_hum = '0; m_tmp = '0; m_ok = 1'b0; m_good = 0; m_fail = 0;
        sv_prev = 1'b0; fail_prev = 1'b0;
      end else begin
        if (sv_prev && m_good < 65535) m_good++;
        if (fail_prev && m_fail < 65535) m_fail++;
        e_sv = exp_h.exists(cyc);
        e_ec = exp_ec.exists(cyc);
        e_fl = exp_fail.exists(cyc);
        if (e_sv) begin
          m_hum = exp_h[cyc];
          m_tmp = exp_t[cyc];
          m_ok  = 1'b1;
        end
        chk("sample_valid", o_sample_valid, e_sv);
        chk("err_checksum", o_err_checksum, e_ec);
        chk("fail", o_fail, e_fl);
        chk("start_allowed", o_dht_start & ~start_ok, 0);
        chk("abort_allowed", o_dht_abort & ~abort_ok, 0);
        chk("err_timeout_allowed", o_err_timeout & ~abort_ok, 0);
        chk("humidity", o_humidity, m_hum);
        chk("temperature", o_temperature, m_tmp);
        chk("data_ok", o_data_ok, m_ok);
        chk("good_cnt", o_good_cnt, STATS ? m_good : 0);
        chk("fail_cnt", o_fail_cnt, STATS ? m_fail : 0);
        sv_prev   = e_sv;
        fail_prev = e_fl;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_start"}, o_dht_start, 0);
    chk({tag, "_abort"}, o_dht_abort, 0);
    chk({tag, "_hum"}, o_humidity, 0);
    chk({tag, "_tmp"}, o_temperature, 0);
    chk({tag, "_data_ok"}, o_data_ok, 0);
    chk({tag, "_sv"}, o_sample_valid, 0);
    chk({tag, "_ecks"}, o_err_checksum, 0);
    chk({tag, "_etmo"}, o_err_timeout, 0);
    chk({tag, "_fail"}, o_fail, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_gcnt"}, o_good_cnt, 0);
    chk({tag, "_fcnt"}, o_fail_cnt, 0);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  // Waits for dht_start; returns its cycle (or -1), leaves one cycle later
  task automatic wait_start(output int s, input int budget);
    int n = 0;
    start_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!o_dht_start && n < budget);
    if (!o_dht_start) begin
      chk("start_seen", 0, 1);
      s = -1;
    end else begin
      s = cyc;
    end
    @(negedge clk);
    start_ok = 1'b0;
  endtask

  // One attempt after a start at s.
  // mode: 0 good, 1 bad checksum, 2 no reply, 3 fixed good, 4 fixed bad,
  //       5 good reply landing on the timeout cycle
  task automatic attempt(input int s, input int mode, input bit last, input int d,
                         output bit good);
    logic [15:0] h, t;
    logic [7:0]  c;
    int n, v, e;
    h = 16'($urandom);
    t = 16'($urandom);
    if (mode == 3 || mode == 4) begin
      h = 16'h028C;
      t = 16'h015F;
    end
    c = h[15:8] + h[7:0] + t[15:8] + t[7:0];
    if (mode == 1) c = c + 8'($urandom_range(1, 255));
    if (mode == 4) c = 8'hEF;
    if (mode == 3) c = 8'hEE;
    good = (mode == 0 || mode == 3 || mode == 5);
    chk("busy_in_wait", o_busy, 1);
    if (mode == 2) begin
      abort_ok = 1'b1;
      n = 0;
      while (!o_dht_abort && n < 80) begin
        @(negedge clk);
        n++;
      end
      chk("abort_seen", o_dht_abort, 1);
      chk("abort_window", (cyc - s >= 40) && (cyc - s <= 56), 1);
      chk("err_timeout_with_abort", o_err_timeout, 1);
      phase = (cyc - 1) % CPM;
      v = cyc + 2;
      if (last) exp_fail[v] = 1'b1;
      @(negedge clk);
      abort_ok = 1'b0;
    end else begin
      if (mode == 5) begin
        e = s + 2;
        while (e % CPM != phase) e++;
        d = e + 4 * CPM - s;
      end
      while (cyc < s + d) @(negedge clk);
      dv = 1'b1; dh = h; dt = t; dc = c;
      v = cyc;
      if (good) begin
        exp_h[v + 2] = h;
        exp_t[v + 2] = t;
      end else begin
        exp_ec[v + 2] = 1'b1;
        if (last) exp_fail[v + 3] = 1'b1;
      end
      @(negedge clk);
      dv = 1'b0;
      v = good ? v + 2 : v + 3;
    end
    while (cyc < v) @(negedge clk);
    if (good) chk("busy_after_good", o_busy, 0);
    if (!good && last) chk("busy_after_fail", o_busy, 0);
  endtask

  // Full transaction: up to MAXR+1 attempts; mode -1 picks a random outcome
  task automatic txn(input int md0, input int md1, input int md2, input int prev,
                     input int glo, input int ghi, input bit drop_en, input bit trig3,
                     output int s0);
    int md[3];
    int s, ps;
    bit good;
    md = '{md0, md1, md2};
    ps = prev;
    s0 = -1;
    for (int a = 0; a <= MAXR; a++) begin
      if (md[a] < 0) md[a] = $urandom_range(0, 2);
      wait_start(s, 900);
      if (s < 0) return;
      if (a == 0) begin
        s0 = s;
        if (glo >= 0) chk("first_start_gap", (s - ps >= glo) && (s - ps <= ghi), 1);
        if (drop_en) enable = 1'b0;
        if (trig3) repeat (3) begin
          pulse_trig();
          @(negedge clk);
        end
      end else begin
        chk("retry_gap", (s - ps >= MINI * CPM - CPM) && (s - ps <= MINI * CPM + 15), 1);
      end
      attempt(s, md[a], a == MAXR, $urandom_range(1, 35), good);
      ps = s;
      if (good) break;
    end
  endtask

  int s1, s2, s3, s4, s5, s6;

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    enable = 1'b1;
    rst_n  = 1'b1;

    // Power-up settle then first periodic read with the reference vector
    txn(3, 0, 0, 0, 195, 208, 1'b0, 1'b0, s1);
    chk("lit_hum", o_humidity, 16'h028C);
    chk("lit_tmp", o_temperature, 16'h015F);
    chk("lit_ok", o_data_ok, 1);

    // Next periodic poll; enable drops mid-transaction, retries still run
    txn(4, 4, 1, s1, POLL * CPM - 10, POLL * CPM + 12, 1'b1, 1'b0, s2);
    chk("held_hum_after_fail", o_humidity, 16'h028C);
    chk("held_tmp_after_fail", o_temperature, 16'h015F);

    // On-demand read with no reply at all: three timeouts then fail
    pulse_trig();
    txn(2, 2, 2, 0, -1, 0, 1'b0, 1'b0, s3);

    // Three merged trigs while busy give exactly one follow-up transaction
    pulse_trig();
    txn(0, 0, 0, 0, -1, 0, 1'b0, 1'b1, s4);
    txn(5, 0, 0, s4, MINI * CPM - CPM, MINI * CPM + 15, 1'b0, 1'b0, s5);
    repeat (700) @(negedge clk);
    chk("idle_after_merge", o_busy, 0);

    // Random transaction interrupted by reset while waiting for the sensor
    pulse_trig();
    wait_start(s6, 900);
    while (cyc < s6 + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    exp_h.delete(); exp_t.delete(); exp_ec.delete(); exp_fail.delete();
    abort_ok = 1'b0;
    start_ok = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_after_reset", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cyc %0d: got running, expected finished", cyc);
    $fatal(1, "time limit");
  end

endmodule
